// File: rtl/resonator_capture_buffer.sv
// Capture buffer for resonator output samples: arm, trigger, fill DEPTH words.
// Define RESONATOR_CAPTURE_PEAK_EN to add peak magnitude/index tracking.
module resonator_capture_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_en,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              abort,
    input  logic [DATA_W-1:0] threshold,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              armed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
`ifdef RESONATOR_CAPTURE_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_idx
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = CNT_FULL - CNT_ONE;

    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W:0]   count_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              peak_clr;
    logic [DATA_W-1:0] sample_abs;
    logic              thr_hit;

    logic [DATA_W-1:0] mem [DEPTH];

    // Saturating magnitude: the most negative code maps to the largest positive.
    always_comb begin
        sample_abs = sample_in;
        if (sample_in == MOST_NEG) begin
            sample_abs = MAX_POS;
        end else if (sample_in[DATA_W-1]) begin
            sample_abs = -sample_in;
        end
        thr_hit = sample_en && (sample_abs >= threshold);
    end

    // Next-state, count update and RAM write decode; abort overrides all.
    always_comb begin
        state_n  = state;
        count_n  = count;
        wr_en    = 1'b0;
        wr_addr  = count[ADDR_W-1:0];
        peak_clr = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (arm) begin
                    state_n  = S_ARMED;
                    count_n  = '0;
                    peak_clr = 1'b1;
                end
            end
            S_ARMED: begin
                if (force_trig || thr_hit) begin
                    state_n = S_CAPTURE;
                    if (sample_en) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_n = CNT_ONE;
                    end else begin
                        count_n = '0;
                    end
                end
            end
            S_CAPTURE: begin
                if (sample_en && (count != CNT_FULL)) begin
                    wr_en   = 1'b1;
                    count_n = count + CNT_ONE;
                    if (count == CNT_LAST) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (arm) begin
                    state_n  = S_ARMED;
                    count_n  = '0;
                    peak_clr = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                count_n = '0;
            end
        endcase
        if (abort) begin
            state_n  = S_IDLE;
            count_n  = '0;
            wr_en    = 1'b0;
            peak_clr = 1'b1;
        end
    end

    // State and sample counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // One-hot status flags decoded from the state.
    always_comb begin
        armed = (state == S_ARMED);
        busy  = (state == S_CAPTURE);
        done  = (state == S_DONE);
    end

    // Capture RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= sample_in;
        end
    end

    // Registered readback; a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

`ifdef RESONATOR_CAPTURE_PEAK_EN
    // Peak magnitude tracker; strict compare keeps the first occurrence.
    always_ff @(posedge clk) begin
        if (reset || peak_clr) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (wr_en && (sample_abs > peak_mag)) begin
            peak_mag <= sample_abs;
            peak_idx <= wr_addr;
        end
    end
`endif

endmodule
